// File: rtl/ram_dp_be.sv
// ram_dp_be: simple-dual-port RAM with byte-enable writes, 1/2-cycle registered reads,
// selectable read-during-write behaviour and a sequential zero-fill clear engine.
module ram_dp_be #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_req,
    output logic                    init_busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int NB = DATA_WIDTH/8;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic wr_ok, rd_ok;
    assign init_busy = state == CLEAR;
    assign wr_ok = wr_en && !init_busy;
    assign rd_ok = rd_en && !init_busy;
    always_comb begin
        state_nx = (state == IDLE && clear_req) ? CLEAR : (state == CLEAR && &clr_cnt) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= init_busy ? clr_cnt + 1'b1 : '0;
        end
    end
    // The clear engine owns the array while busy; user writes are dropped then.
    always_ff @(posedge clk) begin
        if (init_busy)
            mem[clr_cnt] <= '0;
        else if (wr_en)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
    // New-data mode forwards the enabled write bytes onto a colliding read.
    always_comb begin
        rd_word = mem[rd_addr];
        for (int i = 0; i < NB; i++)
            if (RDW_MODE != 0 && wr_ok && wr_be[i] && wr_addr == rd_addr)
                rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
    if (RD_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_ok;
                if (rd_ok) rd_data <= rd_word;
            end
        end
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] pipe_data;
        logic                  pipe_vld;
        // Second stage drains regardless of busy so in-flight reads still complete.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_data <= '0;
                pipe_vld  <= 1'b0;
                rd_data   <= '0;
                rd_valid  <= 1'b0;
            end else begin
                pipe_vld <= rd_ok;
                if (rd_ok) pipe_data <= rd_word;
                rd_valid <= pipe_vld;
                if (pipe_vld) rd_data <= pipe_data;
            end
        end
    end
endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: checks two RAM configurations (latency 1/old-data, latency 2/new-data)
// driven in lockstep against a word-array model with per-port response queues.
module tb_ram_dp_be;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [3:0]  wr_addr = '0, rd_addr = '0, wr_be = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    always #5 clk = ~clk;

    ram_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));
    ram_dp_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_busy(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

    int          n_chk = 0, n_fail = 0, cyc_n = 0, clr_left = 16;
    logic [31:0] mdl [16];
    logic [31:0] last_a = '0, last_b = '0;
    logic [31:0] qa_d[$], qb_d[$];
    int          qa_t[$], qb_t[$], va_cyc[$], vb_cyc[$];

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;
    vec_t tv[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
        end
    endtask

    // One clock: inputs applied now (at a falling edge), model advanced at the rising
    // edge, outputs compared at the next falling edge.
    task automatic cyc(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra, input logic cr);
        logic [31:0] old, nw;
        logic        ea, eb;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clear_req = cr;
        @(posedge clk);
        cyc_n++;
        if (clr_left == 0) begin
            if (re) begin
                old = mdl[ra];
                nw = old;
                if (we && wa == ra)
                    for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
                qa_d.push_back(old); qa_t.push_back(cyc_n);
                qb_d.push_back(nw);  qb_t.push_back(cyc_n + 1);
            end
            if (we)
                for (int i = 0; i < 4; i++) if (be[i]) mdl[wa][8*i +: 8] = wd[8*i +: 8];
            if (cr) clr_left = 16;
        end else begin
            mdl[16 - clr_left] = '0;
            clr_left--;
        end
        @(negedge clk);
        ea = qa_t.size() > 0 && qa_t[0] == cyc_n;
        eb = qb_t.size() > 0 && qb_t[0] == cyc_n;
        if (rd_valid_a) va_cyc.push_back(cyc_n);
        if (rd_valid_b) vb_cyc.push_back(cyc_n);
        chk("valid_a", 32'(rd_valid_a), 32'(ea));
        chk("valid_b", 32'(rd_valid_b), 32'(eb));
        if (ea) begin last_a = qa_d.pop_front(); void'(qa_t.pop_front()); end
        if (eb) begin last_b = qb_d.pop_front(); void'(qb_t.pop_front()); end
        chk("data_a", rd_data_a, last_a);
        chk("data_b", rd_data_b, last_b);
        chk("busy_a", 32'(busy_a), 32'(clr_left > 0));
        chk("busy_b", 32'(busy_b), 32'(clr_left > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        wr_en = 0; rd_en = 0; clear_req = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_a", rd_data_a, 0);
        chk("rst_data_b", rd_data_b, 0);
        chk("rst_valid_a", 32'(rd_valid_a), 0);
        chk("rst_valid_b", 32'(rd_valid_b), 0);
        chk("rst_busy_a", 32'(busy_a), 1);
        clr_left = 16; last_a = '0; last_b = '0;
        qa_d.delete(); qa_t.delete(); qb_d.delete(); qb_t.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_len(input logic noisy, output int n);
        n = 0;
        while (busy_a && n < 40) begin
            if (noisy) cyc($urandom_range(0, 1) == 1, 4'($urandom), $urandom, 4'($urandom),
                           $urandom_range(0, 1) == 1, 4'($urandom), $urandom_range(0, 1) == 1);
            else idle(1);
            n++;
        end
    endtask

    task automatic readback_zero();
        va_cyc.delete();
        for (int a = 0; a < 16; a++) begin
            cyc(0, 0, 0, 0, 1, 4'(a), 0);
            idle(3);
            chk("zero_a", rd_data_a, 0);
            chk("zero_b", rd_data_b, 0);
        end
        chk("zero_pulses", 32'(va_cyc.size()), 16);
    endtask

    initial begin
        int n, e0;
        foreach (mdl[i]) mdl[i] = '0;
        tv[0] = '{1, 3, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0};
        tv[1] = '{1, 3, 32'h11223344, 4'b0101, 0, 0, 0, 0};
        tv[2] = '{0, 0, 0, 0, 1, 3, 32'hAA22CC44, 32'hAA22CC44};
        tv[3] = '{1, 5, 32'h0000000F, 4'hF, 0, 0, 0, 0};
        tv[4] = '{1, 5, 32'h000000FF, 4'hF, 1, 5, 32'h0000000F, 32'h000000FF};
        tv[5] = '{0, 0, 0, 0, 1, 5, 32'h000000FF, 32'h000000FF};
        tv[6] = '{1, 6, 32'hFFFFFFFF, 4'h0, 1, 6, 0, 0};
        tv[7] = '{1, 3, 32'h55667788, 4'b1000, 1, 3, 32'hAA22CC44, 32'h5522CC44};
        tv[8] = '{0, 0, 0, 0, 1, 3, 32'h5522CC44, 32'h5522CC44};

        @(negedge clk);
        do_reset();
        clear_len(0, n);
        chk("reset_clear_len", 32'(n), 16);
        readback_zero();

        foreach (tv[i]) begin
            cyc(tv[i].we, tv[i].wa, tv[i].wd, tv[i].be, tv[i].re, tv[i].ra, 0);
            idle(3);
            if (tv[i].re) begin
                chk($sformatf("vec%0d_a", i), rd_data_a, tv[i].ea);
                chk($sformatf("vec%0d_b", i), rd_data_b, tv[i].eb);
            end
        end

        for (int a = 0; a < 6; a++) cyc(1, 4'(a), 32'h100 + 32'(a), 4'hF, 0, 0, 0);
        va_cyc.delete(); vb_cyc.delete();
        e0 = cyc_n + 1;
        for (int a = 0; a < 6; a++) cyc(0, 0, 0, 0, 1, 4'(a), 0);
        idle(3);
        chk("b2b_cnt_a", 32'(va_cyc.size()), 6);
        chk("b2b_cnt_b", 32'(vb_cyc.size()), 6);
        if (va_cyc.size() == 6 && vb_cyc.size() == 6) begin
            chk("b2b_first_a", 32'(va_cyc[0]), 32'(e0));
            chk("b2b_last_a", 32'(va_cyc[5]), 32'(e0 + 5));
            chk("b2b_first_b", 32'(vb_cyc[0]), 32'(e0 + 1));
            chk("b2b_last_b", 32'(vb_cyc[5]), 32'(e0 + 6));
        end

        for (int a = 0; a < 16; a++) cyc(1, 4'(a), $urandom | 32'h1, 4'hF, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 4'd2, 1);
        clear_len(1, n);
        chk("req_clear_len", 32'(n), 16);
        readback_zero();

        cyc(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 0);
        idle(3);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(7);
        do_reset();
        clear_len(0, n);
        chk("rerun_clear_len", 32'(n), 16);
        readback_zero();

        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), $urandom, 4'($urandom),
                $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)), $urandom_range(0, 99) == 0);
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
